// File: rtl/demux_regbank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_regbank_pkg : sizes shared by the write-side demux and muxes   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package demux_regbank_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_N_REGS = 8;
  localparam int DEF_SEL_W  = 3;

endpackage
`default_nettype wire

// File: rtl/demux_regbank_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_regbank_if : write request in, register contents/status out    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface demux_regbank_if
  import demux_regbank_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int N_REGS = DEF_N_REGS,
  parameter int SEL_W  = DEF_SEL_W
);

  logic                    inWe;
  logic [SEL_W-1:0]        inSel;
  logic [WIDTH-1:0]        inD;
  logic [N_REGS*WIDTH-1:0] outQ;
  logic [N_REGS-1:0]       outPend;
  logic                    outDone;
  logic                    outErr;

  modport master (
    output inWe, inSel, inD,
    input  outQ, outPend, outDone, outErr
  );

  modport slave (
    input  inWe, inSel, inD,
    output outQ, outPend, outDone, outErr
  );

endinterface
`default_nettype wire

// File: rtl/demux_regbank_dec_onehot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_regbank_dec_onehot : index + enable to one-hot, 0 if too large |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module demux_regbank_dec_onehot
  import demux_regbank_pkg::*;
#(
  parameter int N_REGS = DEF_N_REGS,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  wire logic [SEL_W-1:0]  sel,
  input  wire logic              en,
  output logic      [N_REGS-1:0] hot
);

  for (genvar i = 0; i < N_REGS; i++) begin : g_bit
    localparam logic [SEL_W-1:0] IDX = SEL_W'(i);
    assign hot[i] = en && (sel == IDX);
  end

endmodule
`default_nettype wire

// File: rtl/demux_regbank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_regbank : two-stage write-back demux into N_REGS registers     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module demux_regbank
  import demux_regbank_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int N_REGS  = DEF_N_REGS,
  parameter int SEL_W   = DEF_SEL_W,
  parameter bit ZERO_R0 = 1'b1
) (
  input wire logic        inClk,
  input wire logic        inRst,
  demux_regbank_if.slave  bus
);

  logic              pend_valid;
  logic [SEL_W-1:0]  pend_sel;
  logic [WIDTH-1:0]  pend_d;
  logic [N_REGS-1:0] pend_hot;
  logic              done;
  logic              err;

  // The same decode drives commit enables and the visible pending flag.
  demux_regbank_dec_onehot #(
    .N_REGS (N_REGS),
    .SEL_W  (SEL_W)
  ) u_dec (
    .sel (pend_sel),
    .en  (pend_valid),
    .hot (pend_hot)
  );

  always_ff @(posedge inClk) begin
    if (inRst) begin
      pend_valid <= 1'b0;
      pend_sel   <= '0;
      pend_d     <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      pend_valid <= bus.inWe;
      if (bus.inWe) begin
        pend_sel <= bus.inSel;
        pend_d   <= bus.inD;
      end
      done <= pend_valid;
      // A valid request that decodes to nothing must be out of range.
      err  <= pend_valid && !(|pend_hot);
    end
  end

  for (genvar i = 0; i < N_REGS; i++) begin : g_reg
    if (ZERO_R0 && (i == 0)) begin : g_zero
      assign bus.outQ[i*WIDTH +: WIDTH] = '0;
    end else begin : g_store
      logic [WIDTH-1:0] value;
      always_ff @(posedge inClk) begin
        if (inRst) begin
          value <= '0;
        end else if (pend_hot[i]) begin
          value <= pend_d;
        end
      end
      assign bus.outQ[i*WIDTH +: WIDTH] = value;
    end
  end

  assign bus.outPend = pend_hot;
  assign bus.outDone = done;
  assign bus.outErr  = err;

endmodule
`default_nettype wire

// File: tb/tb_demux_regbank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_demux_regbank : scoreboard bench, 8-reg/zero-r0 and 6-reg banks   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_demux_regbank;
  import demux_regbank_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int NA = 8;
  localparam int NB = 6;

  typedef struct {
    int           cyc;
    logic [127:0] q;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_regbank_if #(.WIDTH(W), .N_REGS(NA), .SEL_W(3)) bus_a ();
  demux_regbank_if #(.WIDTH(W), .N_REGS(NB), .SEL_W(3)) bus_b ();

  demux_regbank #(.WIDTH(W), .N_REGS(NA), .SEL_W(3), .ZERO_R0(1'b1)) dut_a (
    .inClk (clk),
    .inRst (rst),
    .bus   (bus_a)
  );

  demux_regbank #(.WIDTH(W), .N_REGS(NB), .SEL_W(3), .ZERO_R0(1'b0)) dut_b (
    .inClk (clk),
    .inRst (rst),
    .bus   (bus_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t sb_a[$];
  exp_t sb_b[$];
  logic [W-1:0]    mdl_a [NA];
  logic [W-1:0]    mdl_b [NB];
  logic [NA-1:0]   exp_pend_a = '0;
  logic [NB-1:0]   exp_pend_b = '0;

  function automatic logic [127:0] pack_a();
    logic [127:0] v = '0;
    for (int i = 0; i < NA; i++) v[i*W +: W] = mdl_a[i];
    return v;
  endfunction

  function automatic logic [127:0] pack_b();
    logic [127:0] v = '0;
    for (int i = 0; i < NB; i++) v[i*W +: W] = mdl_b[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: every outDone pulse must match the oldest queued request.
  task automatic monitor(input string tag, input logic done, input logic err,
                         input logic [127:0] q, inout exp_t sb[$]);
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        check({tag, "_unexpected_done"}, 128'd1, 128'd0);
      end else begin
        e = sb.pop_front();
        check({tag, "_done_cycle"}, 128'(cyc), 128'(e.cyc));
        check({tag, "_q"}, q, e.q);
        check({tag, "_err"}, 128'(err), 128'(e.err));
      end
    end else begin
      if (err) check({tag, "_err_without_done"}, 128'd1, 128'd0);
      if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        check({tag, "_missing_done"}, 128'd0, 128'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      monitor("a", bus_a.outDone, bus_a.outErr, 128'(bus_a.outQ), sb_a);
      monitor("b", bus_b.outDone, bus_b.outErr, 128'(bus_b.outQ), sb_b);
    end
  end

  task automatic check_pend();
    check("pend_a", 128'(bus_a.outPend), 128'(exp_pend_a));
    check("pend_b", 128'(bus_b.outPend), 128'(exp_pend_b));
  endtask

  task automatic step(input bit to_a, input bit we, input logic [2:0] sel, input logic [W-1:0] d);
    @(negedge clk);
    #2;
    check_pend();
    rst         = 1'b0;
    bus_a.inWe  = we && to_a;
    bus_a.inSel = sel;
    bus_a.inD   = d;
    bus_b.inWe  = we && !to_a;
    bus_b.inSel = sel;
    bus_b.inD   = d;
    exp_pend_a  = '0;
    exp_pend_b  = '0;
    if (we && to_a) begin
      if (int'(sel) < NA) exp_pend_a[sel] = 1'b1;
      if (int'(sel) < NA && sel != 3'd0) mdl_a[sel] = d;
      sb_a.push_back('{cyc + 2, pack_a(), int'(sel) >= NA});
    end
    if (we && !to_a) begin
      if (int'(sel) < NB) begin
        exp_pend_b[sel] = 1'b1;
        mdl_b[sel]      = d;
      end
      sb_b.push_back('{cyc + 2, pack_b(), int'(sel) >= NB});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, '0);
  endtask

  // Reset for one edge, optionally with a simultaneous write request on bank a.
  task automatic do_reset(input bit we_too, input logic [2:0] sel);
    @(negedge clk);
    #2;
    check_pend();
    rst         = 1'b1;
    bus_a.inWe  = we_too;
    bus_a.inSel = sel;
    bus_a.inD   = '1;
    bus_b.inWe  = 1'b0;
    sb_a.delete();
    sb_b.delete();
    for (int i = 0; i < NA; i++) mdl_a[i] = '0;
    for (int i = 0; i < NB; i++) mdl_b[i] = '0;
    exp_pend_a = '0;
    exp_pend_b = '0;
    @(negedge clk);
    #2;
    rst        = 1'b0;
    bus_a.inWe = 1'b0;
    check("rst_q_a", 128'(bus_a.outQ), 128'd0);
    check("rst_q_b", 128'(bus_b.outQ), 128'd0);
    check("rst_done_a", 128'(bus_a.outDone), 128'd0);
    check("rst_done_b", 128'(bus_b.outDone), 128'd0);
    check("rst_pend_a", 128'(bus_a.outPend), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.inWe = 1'b0; bus_a.inSel = '0; bus_a.inD = '0;
    bus_b.inWe = 1'b0; bus_b.inSel = '0; bus_b.inD = '0;
    for (int i = 0; i < NA; i++) mdl_a[i] = '0;
    for (int i = 0; i < NB; i++) mdl_b[i] = '0;
    repeat (2) @(negedge clk);
    do_reset(1'b0, 3'd0);

    // Single write, pend visible for exactly one cycle.
    step(1'b1, 1'b1, 3'd3, 16'hABCD);
    idle(2);

    // Back-to-back writes, same index twice then another.
    step(1'b1, 1'b1, 3'd5, 16'h1111);
    step(1'b1, 1'b1, 3'd5, 16'h2222);
    step(1'b1, 1'b1, 3'd2, 16'h3333);
    idle(2);

    // Write to hardwired register 0 is dropped without error.
    step(1'b1, 1'b1, 3'd0, 16'hFFFF);
    step(1'b1, 1'b1, 3'd7, 16'h7777);
    idle(2);

    // Out-of-range index on the 6-register bank.
    step(1'b0, 1'b1, 3'd7, 16'h5A5A);
    step(1'b0, 1'b1, 3'd6, 16'hA5A5);
    idle(2);

    // Register 0 writable when not hardwired; highest valid index.
    step(1'b0, 1'b1, 3'd0, 16'h1234);
    step(1'b0, 1'b1, 3'd5, 16'hBEEF);
    idle(2);

    // Captured write discarded by reset on the following edge.
    step(1'b1, 1'b1, 3'd4, 16'h4444);
    do_reset(1'b0, 3'd0);

    // Reset wins over a write on the same edge.
    do_reset(1'b1, 3'd3);
    step(1'b1, 1'b1, 3'd1, 16'hC0DE);
    idle(3);

    check("sb_a_drained", 128'(sb_a.size()), 128'd0);
    check("sb_b_drained", 128'(sb_b.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
